// File: rtl/mini_core_mem_arb.sv
// Two-requester arbiter for the mini core memory port: core data path vs. external agent,
// with region decode onto I_MEM/D_MEM and a one-cycle read response return path.

package mini_core_mem_arb_pkg;

  typedef struct packed {
    logic [31:0] wr_data;
    logic [31:0] address;
    logic        wr_en;
    logic        rd_en;
    logic [3:0]  byte_en;
  } t_core2mem_req;

endpackage

module mini_core_mem_arb
  import mini_core_mem_arb_pkg::*;
#(
  parameter int unsigned LOCK_MAX    = 8,
  parameter int unsigned I_MEM_FLOOR = 32'h0_0000,
  parameter int unsigned I_MEM_ROOF  = 32'h0_FFFF,
  parameter int unsigned D_MEM_FLOOR = 32'h1_0000,
  parameter int unsigned D_MEM_ROOF  = 32'h1_FFFF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  t_core2mem_req core_req,
  output logic          core_req_ready,
  output logic          core_rsp_valid,
  output logic [31:0]   core_rsp_data,
  output logic          core_rsp_err,
  input  t_core2mem_req ext_req,
  input  logic          ext_lock,
  output logic          ext_req_ready,
  output logic          ext_rsp_valid,
  output logic [31:0]   ext_rsp_data,
  output logic          ext_rsp_err,
  output t_core2mem_req mem_req,
  output logic          mem_sel_imem,
  output logic          mem_sel_dmem,
  input  logic [31:0]   mem_rd_data
);

  localparam int unsigned CNT_W    = $clog2(LOCK_MAX + 1);
  localparam int unsigned REGION_W = 18;

  localparam logic [1:0] RR_CORE_PRI = 2'd0;
  localparam logic [1:0] RR_EXT_PRI  = 2'd1;
  localparam logic [1:0] EXT_LOCKED  = 2'd2;

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic [CNT_W-1:0]    lock_cnt;
  logic [CNT_W-1:0]    lock_cnt_nxt;
  logic [CNT_W-1:0]    cnt_inc;
  logic                core_vld;
  logic                ext_vld;
  logic                gnt_core;
  logic                gnt_ext;
  logic                any_gnt;
  t_core2mem_req       gnt_req;
  logic [REGION_W-1:0] off_i;
  logic [REGION_W-1:0] off_d;
  logic                addr_hi_zero;
  logic                in_imem;
  logic                in_dmem;
  logic                mapped;
  logic                gnt_read;
  logic                rsp_vld_q;
  logic                rsp_ext_q;
  logic                rsp_err_q;

  assign core_vld = core_req.wr_en | core_req.rd_en;
  assign ext_vld  = ext_req.wr_en | ext_req.rd_en;

  // Arbitration state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RR_CORE_PRI;
      lock_cnt <= '0;
    end else begin
      state    <= state_nxt;
      lock_cnt <= lock_cnt_nxt;
    end
  end

  // Grant and next state; grants are held off while reset is asserted so outputs read 0
  always_comb begin
    state_nxt    = state;
    lock_cnt_nxt = lock_cnt;
    gnt_core     = 1'b0;
    gnt_ext      = 1'b0;
    cnt_inc      = (state == EXT_LOCKED) ? lock_cnt + CNT_W'(1) : CNT_W'(1);

    if (rst_n) begin
      case (state)
        RR_CORE_PRI: begin
          gnt_core = core_vld;
          gnt_ext  = ext_vld & ~core_vld;
        end
        RR_EXT_PRI, EXT_LOCKED: begin
          gnt_ext  = ext_vld;
          gnt_core = core_vld & ~ext_vld;
        end
        default: begin
          state_nxt    = RR_CORE_PRI;
          lock_cnt_nxt = '0;
        end
      endcase
    end

    // A locked ext burst ends when the lock drops or the run reaches LOCK_MAX
    if (gnt_ext) begin
      if (ext_lock && (cnt_inc < CNT_W'(LOCK_MAX))) begin
        state_nxt    = EXT_LOCKED;
        lock_cnt_nxt = cnt_inc;
      end else begin
        state_nxt    = RR_CORE_PRI;
        lock_cnt_nxt = '0;
      end
    end else if (gnt_core && (state != EXT_LOCKED)) begin
      state_nxt = RR_EXT_PRI;
    end
  end

  assign core_req_ready = gnt_core;
  assign ext_req_ready  = gnt_ext;
  assign any_gnt        = gnt_core | gnt_ext;

  // Region decode and forwarding of the granted request
  always_comb begin
    gnt_req      = gnt_ext ? ext_req : (gnt_core ? core_req : '0);
    addr_hi_zero = (gnt_req.address[31:REGION_W] == '0);
    off_i        = gnt_req.address[REGION_W-1:0] - REGION_W'(I_MEM_FLOOR);
    off_d        = gnt_req.address[REGION_W-1:0] - REGION_W'(D_MEM_FLOOR);
    in_imem      = addr_hi_zero & (off_i <= REGION_W'(I_MEM_ROOF - I_MEM_FLOOR));
    in_dmem      = addr_hi_zero & (off_d <= REGION_W'(D_MEM_ROOF - D_MEM_FLOOR));
    mapped       = in_imem | in_dmem;
    mem_sel_imem = any_gnt & in_imem;
    mem_sel_dmem = any_gnt & in_dmem & ~in_imem;
    gnt_read     = any_gnt & gnt_req.rd_en & ~gnt_req.wr_en;

    mem_req = gnt_req;
    if (!mapped) begin
      mem_req.wr_en = 1'b0;
      mem_req.rd_en = 1'b0;
    end else if (gnt_req.wr_en) begin
      mem_req.rd_en = 1'b0;
    end
  end

  // Read response pipe: owner, valid and error one cycle behind the grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld_q <= 1'b0;
      rsp_ext_q <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      rsp_vld_q <= gnt_read;
      rsp_ext_q <= gnt_ext;
      rsp_err_q <= ~mapped;
    end
  end

  assign core_rsp_valid = rsp_vld_q & ~rsp_ext_q;
  assign core_rsp_err   = core_rsp_valid & rsp_err_q;
  assign core_rsp_data  = (core_rsp_valid & ~rsp_err_q) ? mem_rd_data : '0;

  assign ext_rsp_valid  = rsp_vld_q & rsp_ext_q;
  assign ext_rsp_err    = ext_rsp_valid & rsp_err_q;
  assign ext_rsp_data   = (ext_rsp_valid & ~rsp_err_q) ? mem_rd_data : '0;

endmodule
